barker_frame_sync_ctrl: RTL
===========================

// Module: barker_frame_sync_ctrl
// PURPOSE
//  Frame-synchronisation controller sequenced by the Barker correlator's 1-bit AXIS result stream
//  (tdata=1: correlation peak on this bit). Runs a HUNT/CONFIRM/LOCK/FLYWHEEL state machine over
//  accepted beats, predicts the next peak position, declares lock, and flags each frame start.
//  Sits in the correlator clock domain directly after correlation_barker_wrapper's m_axis.
// PARAMETERS
//  FRAME_LEN    32  beats between consecutive Barker peaks (>=2)
//  CONFIRM_CNT  3   consecutive on-time peaks after first hit required to enter LOCK (>=1)
//  MISS_MAX     2   consecutive missed peaks tolerated in FLYWHEEL; next miss -> HUNT (>=1)
//  ERR_W        16  width of saturating statistics counters
// PORTS
//  i_clk          in   1          correlator clock; all logic on rising edge
//  i_rst          in   1          synchronous reset, active high
//  s_axis_tdata   in   1          correlator result bit, 1 = peak
//  s_axis_tvalid  in   1          result beat valid
//  s_axis_tready  out  1          controller ready
//  o_state        out  2          0 HUNT, 1 CONFIRM, 2 LOCK, 3 FLYWHEEL
//  o_locked       out  1          high in LOCK or FLYWHEEL
//  o_frame_start  out  1          1-cycle pulse: expected-position beat accepted while locked
//  o_beat_pos     out  $clog2(FRAME_LEN)  position of last accepted beat within frame
//  o_loss_cnt     out  ERR_W      lock losses (LOCK/FLYWHEEL -> HUNT), saturating
//  o_spur_cnt     out  ERR_W      peaks at non-expected positions while locked, saturating
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): state HUNT, all outputs 0 incl. s_axis_tready; pos counter 0.
//    Reset mid-frame discards lock and counters immediately; no pulse in reset cycle.
//  - s_axis_tready registered: 1 from first cycle after reset deasserts; never drops otherwise.
//  - Only accepted beats (tvalid & tready) advance anything; tvalid low = stall, state frozen.
//  - Position: accepted beat when pos==FRAME_LEN-1 is the "expected" beat and gets pos 0;
//    otherwise pos+1 (wraps mod FRAME_LEN, also non-power-of-2 lengths).
//  - HUNT: peak -> pos<=0, hit_cnt<=0, CONFIRM. No peak -> stay, pos not tracked (held 0).
//  - CONFIRM: expected beat with peak -> hit_cnt+1; at hit_cnt==CONFIRM_CNT-1 -> LOCK.
//    Expected beat without peak -> HUNT. Peak at non-expected pos -> restart CONFIRM with pos<=0.
//  - LOCK: expected beat with peak -> stay, miss_cnt<=0; without peak -> FLYWHEEL, miss_cnt<=1.
//  - FLYWHEEL: expected beat with peak -> LOCK, miss_cnt<=0; without peak: miss_cnt==MISS_MAX
//    -> HUNT, o_loss_cnt+1; else miss_cnt+1.
//  - Locked spurious peaks (non-expected pos) ignored for timing; o_spur_cnt+1.
//  - o_frame_start: registered, high 1 cycle after every expected beat accepted in LOCK or
//    FLYWHEEL (hit or flywheel-predicted), including the one causing FLYWHEEL->HUNT... no: pulse
//    is suppressed on the beat that leaves lock; the LOCK-entry beat does pulse.
//  - o_state/o_locked/o_beat_pos update 1 cycle after the accepted beat (all outputs registered).
//  - Counters saturate at 2^ERR_W-1, never wrap.
//  - Latency input beat -> status outputs: 1 cycle. Throughput: 1 beat/cycle.
// TESTING  (bench uses FRAME_LEN=8, CONFIRM_CNT=3, MISS_MAX=2)
//  1 Reset: hold i_rst 3 cycles with tvalid=1 -> all outputs 0, tready 0; tready=1 next cycle.
//  2 Peaks every 8 beats, continuous valid -> CONFIRM after 1st, LOCK 1 cycle after 4th peak
//    (beat 24); o_frame_start every 8 cycles thereafter, o_beat_pos cycles 0..7.
//  3 Locked, drop 2 peaks then resume -> LOCK->FLYWHEEL->FLYWHEEL->LOCK, frame_start uninterrupted,
//    o_loss_cnt 0. Drop 3 peaks -> HUNT on 3rd miss, o_loss_cnt=1, o_locked=0.
//  4 Locked, extra peak at pos 3 -> o_spur_cnt=1, timing unchanged, state LOCK.
//  5 Random tvalid gaps (50% duty) with peaks every 8 accepted beats -> same state sequence as 2.
//  6 CONFIRM with 2nd peak arriving at pos 5 -> restart CONFIRM, pos 0 at that beat; assert i_rst
//    while in LOCK -> HUNT and zeroed counters next cycle.

Source files
------------

// File: rtl/barker_frame_sync_ctrl.sv
// Frame-synchronisation controller driven by the Barker correlator's 1-bit AXIS result stream.
// Runs HUNT/CONFIRM/LOCK/FLYWHEEL over accepted beats, tracks the position within the frame,
// declares lock and pulses once per predicted frame start while locked.
//
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset
//   s_axis_tdata      correlator result bit (1 = peak)
//   s_axis_tvalid     result beat valid
//   s_axis_tready     registered ready, high from the first cycle after reset
//   o_state           0 HUNT, 1 CONFIRM, 2 LOCK, 3 FLYWHEEL
//   o_locked          high in LOCK or FLYWHEEL
//   o_frame_start     1-cycle pulse after each expected beat accepted while locked
//   o_beat_pos        position of the last accepted beat within the frame
//   o_loss_cnt        saturating count of lock losses
//   o_spur_cnt        saturating count of peaks at non-expected positions while locked
module barker_frame_sync_ctrl #(
  parameter int unsigned FRAME_LEN   = 32,
  parameter int unsigned CONFIRM_CNT = 3,
  parameter int unsigned MISS_MAX    = 2,
  parameter int unsigned ERR_W       = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [1:0]                   o_state,
  output logic                         o_locked,
  output logic                         o_frame_start,
  output logic [$clog2(FRAME_LEN)-1:0] o_beat_pos,
  output logic [ERR_W-1:0]             o_loss_cnt,
  output logic [ERR_W-1:0]             o_spur_cnt
);

  localparam int unsigned PosW  = $clog2(FRAME_LEN);
  localparam int unsigned HitW  = $clog2(CONFIRM_CNT + 1);
  localparam int unsigned MissW = $clog2(MISS_MAX + 1);

  localparam logic [PosW-1:0]  PosLast = PosW'(FRAME_LEN - 1);
  localparam logic [HitW-1:0]  HitLast = HitW'(CONFIRM_CNT - 1);
  localparam logic [MissW-1:0] MissMax = MissW'(MISS_MAX);

  typedef enum logic [1:0] {
    StHunt     = 2'd0,
    StConfirm  = 2'd1,
    StLock     = 2'd2,
    StFlywheel = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic [HitW-1:0]    hit_q, hit_d;
  logic [MissW-1:0]   miss_q, miss_d;
  logic [ERR_W-1:0]   loss_q, loss_d;
  logic [ERR_W-1:0]   spur_q, spur_d;
  logic               fs_q, fs_d;
  logic               ready_q;

  logic accept;
  logic expected;

  assign accept   = s_axis_tvalid & ready_q;
  // The beat that follows position FRAME_LEN-1 is where the next peak should land.
  assign expected = (pos_q == PosLast);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    loss_d  = loss_q;
    spur_d  = spur_q;
    fs_d    = 1'b0;

    if (accept) begin
      pos_d = expected ? '0 : pos_q + PosW'(1);
      unique case (state_q)
        StHunt: begin
          // Position is not tracked until a first peak anchors it.
          pos_d = '0;
          if (s_axis_tdata) begin
            state_d = StConfirm;
            hit_d   = '0;
          end
        end
        StConfirm: begin
          if (expected) begin
            if (s_axis_tdata) begin
              if (hit_q == HitLast) begin
                state_d = StLock;
                miss_d  = '0;
                fs_d    = 1'b1;
              end else begin
                hit_d = hit_q + HitW'(1);
              end
            end else begin
              state_d = StHunt;
            end
          end else if (s_axis_tdata) begin
            // Off-time peak: treat it as a new candidate anchor.
            pos_d = '0;
            hit_d = '0;
          end
        end
        StLock: begin
          if (expected) begin
            fs_d = 1'b1;
            if (s_axis_tdata) begin
              miss_d = '0;
            end else begin
              state_d = StFlywheel;
              miss_d  = MissW'(1);
            end
          end else if (s_axis_tdata) begin
            if (spur_q != '1) spur_d = spur_q + ERR_W'(1);
          end
        end
        StFlywheel: begin
          if (expected) begin
            if (s_axis_tdata) begin
              state_d = StLock;
              miss_d  = '0;
              fs_d    = 1'b1;
            end else if (miss_q == MissMax) begin
              // Leaving lock: no frame-start pulse on this beat.
              state_d = StHunt;
              miss_d  = '0;
              if (loss_q != '1) loss_d = loss_q + ERR_W'(1);
            end else begin
              miss_d = miss_q + MissW'(1);
              fs_d   = 1'b1;
            end
          end else if (s_axis_tdata) begin
            if (spur_q != '1) spur_d = spur_q + ERR_W'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StHunt;
      pos_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      loss_q  <= '0;
      spur_q  <= '0;
      fs_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      loss_q  <= loss_d;
      spur_q  <= spur_d;
      fs_q    <= fs_d;
      ready_q <= 1'b1;
    end
  end

  assign s_axis_tready = ready_q;
  assign o_state       = state_q;
  assign o_locked      = (state_q == StLock) || (state_q == StFlywheel);
  assign o_frame_start = fs_q;
  assign o_beat_pos    = pos_q;
  assign o_loss_cnt    = loss_q;
  assign o_spur_cnt    = spur_q;

endmodule
